// File: rtl/scan_display_driver.sv
// Time-multiplexed driver for a bank of common-cathode 7-segment digits.
// Holds a shadow copy of the BCD value, scans one digit every SCAN_DIV
// cycles, and applies blank/lamp-test/leading-zero/blink controls before
// registering segments and the one-hot digit strobe on the same edge.
module scan_display_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic                  LT,
    input  logic                  RBI,
    input  logic                  BI,
    input  logic [DIGITS-1:0]     blink,
    output logic [6:0]            display,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*DIGITS-1:0] shadow;
    logic [PW-1:0]       prescale;
    logic [IW-1:0]       index;
    logic [FW-1:0]       frame_cnt;
    logic                blink_phase;
    logic                wrap_d;

    logic                digit_end;
    logic                frame_end;
    logic [DIGITS-1:0]   lead_zero;
    logic                upper_zero;
    logic [3:0]          cur_nibble;
    logic                cur_lz;
    logic                cur_blink;
    logic [DIGITS-1:0]   sel_next;
    logic [6:0]          seg_next;

    // 7448-style decode, bit 6 = segment a ... bit 0 = segment g.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b0011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1110011;
            4'd10:   s = 7'b0001101;
            4'd11:   s = 7'b0011001;
            4'd12:   s = 7'b0100011;
            4'd13:   s = 7'b1001011;
            4'd14:   s = 7'b0001111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Terminal-count detection for the digit dwell and for the full frame.
    always_comb begin
        digit_end = (prescale == PW'(SCAN_DIV - 1));
        frame_end = digit_end && (index == IW'(DIGITS - 1));
    end

    // Leading-zero flags: scan from the top digit down, a digit is a leading
    // zero while every digit at or above it is zero; digit 0 never qualifies.
    always_comb begin
        upper_zero = 1'b1;
        lead_zero  = '0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            upper_zero   = upper_zero && (shadow[4*i +: 4] == 4'd0);
            lead_zero[i] = upper_zero;
        end
    end

    // Select the current digit's nibble, flags and one-hot strobe.
    always_comb begin
        cur_nibble = '0;
        cur_lz     = 1'b0;
        cur_blink  = 1'b0;
        sel_next   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (index == IW'(i)) begin
                cur_nibble  = shadow[4*i +: 4];
                cur_lz      = lead_zero[i];
                cur_blink   = blink[i];
                sel_next[i] = 1'b1;
            end
        end
    end

    // Segment priority: blank-all, lamp test, leading-zero, blink, decode.
    always_comb begin
        seg_next = decode(cur_nibble);
        if (BI) begin
            seg_next = '0;
        end else if (LT) begin
            seg_next = '1;
        end else if (RBI && cur_lz) begin
            seg_next = '0;
        end else if (blink_phase && cur_blink) begin
            seg_next = '0;
        end
    end

    // Shadow register: only path from data to the decoder.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= data;
        end
    end

    // Prescaler, digit index, frame counter and blink phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale    <= '0;
            index       <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            wrap_d      <= 1'b0;
        end else begin
            prescale <= digit_end ? '0 : prescale + PW'(1);
            if (digit_end) begin
                index <= (index == IW'(DIGITS - 1)) ? '0 : index + IW'(1);
            end
            if (frame_end) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
            // Outputs lag the index by one edge, so the wrap pulse is delayed
            // to land on the edge where digit_sel returns to digit 0.
            wrap_d <= frame_end;
        end
    end

    // Registered outputs: segments and strobe update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            display    <= '0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            display    <= seg_next;
            digit_sel  <= sel_next;
            frame_done <= wrap_d;
        end
    end

endmodule

// File: doc/scan_display_driver.md
# scan_display_driver

Time-multiplexed driver for a bank of common-cathode 7-segment digits. It generalises our single-digit Standard_7448 decoding to `DIGITS` digits, adding a shadow data register, a scan prescaler and a one-hot digit strobe. It also adds multi-digit leading-zero blanking and a per-digit blink mask. It sits between the charger's countdown/balance logic and the front-panel display pins.

## Interface
- `DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `SCAN_DIV`, default 1000: clock cycles each digit stays lit; must be ≥ 2.
- `BLINK_FRAMES`, default 64: full scan frames per blink half-period; must be ≥ 1.

Ports:
- `clk`  in  1: single system clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `data`  in  4*DIGITS: BCD digits; digit i = `data[4i+3:4i]`; digit 0 = least significant.
- `load`  in  1: when high at an edge, `data` is copied into the shadow register.
- `LT`  in  1: lamp test, active-high; lights all segments of every digit.
- `RBI`  in  1: active-high leading-zero blanking enable.
- `BI`  in  1: active-high blank-all.
- `blink`  in  DIGITS: per-digit blink mask; bit i = digit i.
- `display`  out  7: registered segments, `display[6:0]` = a,b,c,d,e,f,g; 1 = lit.
- `digit_sel`  out  DIGITS: registered one-hot digit enable; bit i = digit i.
- `frame_done`  out  1: registered one-cycle pulse at the end of each full scan.

## Operation
- **Shadow register**: 4*DIGITS bits; captures `data` when `load` is 1. The decoder reads only the shadow, never `data` directly.
- **Prescaler**: counts 0..SCAN_DIV-1 and wraps. At the terminal count, the digit index advances as index+1 mod DIGITS.
- **Frame counter**: counts index wraps (DIGITS-1 → 0) modulo BLINK_FRAMES. `blink_phase` toggles when the frame counter wraps.
- **Decode of nibble v** (segments listed are lit), per Standard_7448:
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg.
  - 5 acdfg, 6 cdefg, 7 abc, 8 abcdefg, 9 abcfg.
  - 10 deg, 11 cdg, 12 bfg, 13 adfg, 14 defg, 15 blank.
- **Leading zero**: digit i is a leading zero when i ≥ 1 and digits i..DIGITS-1 of the shadow are all 0. Digit 0 is never a leading zero, so an all-zero value shows a single "0".
- **Segment priority**, highest first:
  1. `reset`: 7'b0.
  2. `BI=1`: 7'b0.
  3. `LT=1`: 7'b1111111.
  4. `RBI=1` and current digit is a leading zero: 7'b0.
  5. `blink_phase=1` and `blink[index]=1`: 7'b0.
  6. Otherwise the decode of the current digit.
- **digit_sel**: one-hot of the index. It stays driven even while `display` is blanked by BI, blink or RBI.
- **frame_done**: 1 for exactly one cycle, coincident with the edge that moves `digit_sel` from bit DIGITS-1 to bit 0.

## Timing
- **Reset values**: `display`=0, `digit_sel`=0, `frame_done`=0. Prescaler, index, frame counter, `blink_phase` and shadow are all 0.
- **First cycle after reset release**: `digit_sel`=1 (digit 0), `display` = decode of shadow digit 0 under the current controls.
- **Per-cycle recompute**: `display` and `digit_sel` are recomputed every cycle from the registered index, shadow and the current `LT`/`BI`/`RBI`/`blink`.
- **Latency**:
  - Control inputs reach `display` 1 cycle later.
  - `load` reaches `display` 2 cycles later (shadow, then output).
- **Digit dwell**: each digit is presented for exactly SCAN_DIV consecutive cycles. One frame = DIGITS*SCAN_DIV cycles.
- **Blink half-period**: BLINK_FRAMES*DIGITS*SCAN_DIV cycles. The first `blink_phase` rise occurs at the end of frame BLINK_FRAMES after reset.
- **Load mid-dwell**: takes effect without restarting the prescaler or index. No frame resynchronisation.
- **Simultaneous load and decode**: the output in the same cycle uses the old shadow.
- **Reset mid-scan**: the next edge forces all reset values regardless of other inputs.
- **Glitch-free**: `display` and `digit_sel` switch on the same edge, so no cycle shows a new digit's enable with the old digit's segments.

## Test plan
Benches use DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2 unless noted.

1. **Reset and scan order**: hold `reset` 3 cycles, then load `data`=16'h1234.
   - During reset: `display`=0, `digit_sel`=0.
   - Afterwards `digit_sel` cycles 0001→0010→0100→1000, 4 cycles each.
   - `display` reads 0110011 ("4"), 1111001 ("3"), 1101101 ("2"), 0110000 ("1").
   - `frame_done` pulses once every 16 cycles.
2. **Full decode**: sweep digit 0 through 0..15 with `load`. Each value must match the table, e.g. 6→0011111, 9→1110011, 15→0000000.
3. **Leading-zero blanking**: `data`=16'h0070 with `RBI`=1.
   - Digits 3 and 2 blank, digit 1 = 1110000, digit 0 = 1111110.
   - `data`=16'h0000: only digit 0 lit, 1111110.
   - `RBI`=0: all four digits show "0".
4. **Priority**:
   - `LT`=1 with `RBI`=1 and `data`=0: all digits 1111111.
   - `LT`=1 with `BI`=1: all digits 0000000, while `digit_sel` keeps scanning.
5. **Blink**: `blink`=4'b0010, `data`=16'h5555.
   - Frames 0–1: digit 1 = 1011011.
   - Frames 2–3: digit 1 = 0000000; other digits unaffected.
   - Frames 4–5: digit 1 lit again.
6. **Reset mid-scan and load timing**:
   - Assert `reset` while digit 2 is lit: the next edge gives `digit_sel`=0 and `display`=0, and the shadow clears to 0.
   - Load 16'h0009 mid-dwell on digit 0: "9" appears exactly 2 cycles after `load`, with dwell unchanged.
